machine_timer: RTL and testbench

Memory-mapped machine timer and the source end of the clock interrupt line. Holds a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and a control register, all on the CPU data bus. It drives a level interrupt into `irq_pins[CLOCK_IRQ_PIN]` of the interrupt manager, which turns it into a trap with mcause `CLOCK_INT_MCAUSE`.

---
 rtl/machine_timer_pkg.sv | 29 ++
 rtl/mtimer_prescaler.sv | 30 +++
 rtl/machine_timer.sv | 142 ++++++++++++++
 tb/tb_machine_timer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/machine_timer_pkg.sv
// Shared constants for the machine timer: register offsets within the 32-byte
// window, CTRL bit positions and the mtimecmp reset value.
package machine_timer_pkg;

  // Byte offsets inside the register window (addr[4:0])
  localparam logic [4:0] MTIMER_OFF_MTIME_LO      = 5'h00;
  localparam logic [4:0] MTIMER_OFF_MTIME_HI      = 5'h04;
  localparam logic [4:0] MTIMER_OFF_MTIMECMP_LO   = 5'h08;
  localparam logic [4:0] MTIMER_OFF_MTIMECMP_HI   = 5'h0C;
  localparam logic [4:0] MTIMER_OFF_CTRL          = 5'h10;
  localparam logic [4:0] MTIMER_OFF_MTIME_HI_SNAP = 5'h14;

  // CTRL layout: EN at bit 0, 8-bit PRESCALE field starting at bit 8
  localparam int unsigned MTIMER_CTRL_EN       = 0;
  localparam int unsigned MTIMER_CTRL_PRESCALE = 8;

  // mtimecmp resets to all-ones so the interrupt cannot fire before software sets it
  localparam logic [63:0] MTIMER_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Assemble the CTRL read value; unused bits read as zero
  function automatic logic [31:0] mtimer_ctrl_word(input logic en, input logic [7:0] prescale);
    logic [31:0] w;
    w = '0;
    w[MTIMER_CTRL_EN] = en;
    w[MTIMER_CTRL_PRESCALE +: 8] = prescale;
    return w;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescale counter for the machine timer. Counts 0..prescale while enabled and
// emits a one-cycle tick when the count equals prescale. Only built when
// MACHINE_TIMER_PRESCALE_EN is defined; otherwise the top ticks every enabled cycle.
`ifdef MACHINE_TIMER_PRESCALE_EN
module mtimer_prescaler (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       en,
  input  logic       restart,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] cnt_q;

  assign tick = en && (cnt_q == prescale);

  // Counter returns to 0 on tick, restart (CTRL write) or while disabled
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt_q <= 8'd0;
    end else if (restart || !en || tick) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/machine_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, CTRL and an mtime[63:32]
// snapshot register, driving a registered level interrupt. The prescaler is
// present only when MACHINE_TIMER_PRESCALE_EN is defined.
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0100
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        timer_irq
);

  logic       sel;
  logic [4:0] off;
  logic       wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
  logic       rd_mtime_lo;
  logic       tick;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic [31:0] snap_q, snap_d;
  logic        irq_q, irq_d;
  logic [7:0]  prescale_rd;

  assign sel = (addr[31:5] == BASE_ADDR[31:5]);
  assign off = addr[4:0];

  assign wr_mtime_lo = we && sel && (off == MTIMER_OFF_MTIME_LO);
  assign wr_mtime_hi = we && sel && (off == MTIMER_OFF_MTIME_HI);
  assign wr_cmp_lo   = we && sel && (off == MTIMER_OFF_MTIMECMP_LO);
  assign wr_cmp_hi   = we && sel && (off == MTIMER_OFF_MTIMECMP_HI);
  assign wr_ctrl     = we && sel && (off == MTIMER_OFF_CTRL);
  assign rd_mtime_lo = re && sel && (off == MTIMER_OFF_MTIME_LO);

`ifdef MACHINE_TIMER_PRESCALE_EN
  logic [7:0] prescale_q, prescale_d;

  // PRESCALE field of CTRL
  always_comb begin
    prescale_d = prescale_q;
    if (wr_ctrl) begin
      prescale_d = wdata[MTIMER_CTRL_PRESCALE +: 8];
    end
  end

  // PRESCALE register
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      prescale_q <= 8'd0;
    end else begin
      prescale_q <= prescale_d;
    end
  end

  assign prescale_rd = prescale_q;

  mtimer_prescaler u_prescaler (
    .clk      (clk),
    .clr_n    (clr_n),
    .en       (en_q),
    .restart  (wr_ctrl),
    .prescale (prescale_q),
    .tick     (tick)
  );
`else
  assign prescale_rd = 8'd0;
  assign tick        = en_q;
`endif

  // Next-state: bus writes take priority over the tick, which is dropped that cycle
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    snap_d     = snap_q;
    if (wr_mtime_lo) begin
      mtime_d[31:0] = wdata;
    end else if (wr_mtime_hi) begin
      mtime_d[63:32] = wdata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (wr_cmp_lo) begin
      mtimecmp_d[31:0] = wdata;
    end
    if (wr_cmp_hi) begin
      mtimecmp_d[63:32] = wdata;
    end
    if (wr_ctrl) begin
      en_d = wdata[MTIMER_CTRL_EN];
    end
    // Reading LO freezes the upper half so LO+SNAP form a consistent pair
    if (rd_mtime_lo) begin
      snap_d = mtime_q[63:32];
    end
    // Compare uses pre-edge register values, hence one cycle of IRQ latency
    irq_d = en_q && (mtime_q >= mtimecmp_q);
  end

  // Timer state registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= MTIMER_MTIMECMP_RST;
      en_q       <= 1'b0;
      snap_q     <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      snap_q     <= snap_d;
      irq_q      <= irq_d;
    end
  end

  assign timer_irq = irq_q;

  // Combinational read mux; unselected or unmapped offsets read 0
  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (off)
        MTIMER_OFF_MTIME_LO:      rdata = mtime_q[31:0];
        MTIMER_OFF_MTIME_HI:      rdata = mtime_q[63:32];
        MTIMER_OFF_MTIMECMP_LO:   rdata = mtimecmp_q[31:0];
        MTIMER_OFF_MTIMECMP_HI:   rdata = mtimecmp_q[63:32];
        MTIMER_OFF_CTRL:          rdata = mtimer_ctrl_word(en_q, prescale_rd);
        MTIMER_OFF_MTIME_HI_SNAP: rdata = snap_q;
        default:                  rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer: directed scenarios plus a randomized
// bus sequence checked against a cycle-level behavioural model.
module tb_machine_timer;

  localparam logic [31:0] BASE = 32'hFFFF_0100;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        timer_irq;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  machine_timer #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .we        (we),
    .re        (re),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .timer_irq (timer_irq)
  );

  // Behavioural model; prescale expressed as enabled-cycle age modulo (PRESCALE+1)
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_en;
  logic [7:0]  m_pre;
  logic [31:0] m_snap;
  logic        m_irq;
  int          m_age;

  always @(posedge clk) begin
    logic sel;
    logic [4:0] o;
    bit tk;
    sel = ((addr >> 5) == (BASE >> 5));
    o = addr[4:0];
    if (!clr_n) begin
      m_mtime <= 64'd0;
      m_cmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
      m_en    <= 1'b0;
      m_pre   <= 8'd0;
      m_snap  <= 32'd0;
      m_irq   <= 1'b0;
      m_age   <= 0;
    end else begin
      tk = m_en && ((m_age % (int'(m_pre) + 1)) == int'(m_pre));
      m_irq <= m_en && (m_mtime >= m_cmp);
      m_age <= (!m_en || (we && sel && o == 5'h10)) ? 0 : m_age + 1;
      if (we && sel && o == 5'h00)      m_mtime <= {m_mtime[63:32], wdata};
      else if (we && sel && o == 5'h04) m_mtime <= {wdata, m_mtime[31:0]};
      else if (tk)                      m_mtime <= m_mtime + 64'd1;
      if (we && sel && o == 5'h08) m_cmp <= {m_cmp[63:32], wdata};
      if (we && sel && o == 5'h0C) m_cmp <= {wdata, m_cmp[31:0]};
      if (we && sel && o == 5'h10) begin
        m_en <= wdata[0];
`ifdef MACHINE_TIMER_PRESCALE_EN
        m_pre <= wdata[15:8];
`else
        m_pre <= 8'd0;
`endif
      end
      if (re && sel && o == 5'h00) m_snap <= m_mtime[63:32];
    end
  end

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if ((a >> 5) != (BASE >> 5)) return 32'd0;
    case (a[4:0])
      5'h00:   return m_mtime[31:0];
      5'h04:   return m_mtime[63:32];
      5'h08:   return m_cmp[31:0];
      5'h0C:   return m_cmp[63:32];
      5'h10:   return {16'h0, m_pre, 7'h0, m_en};
      5'h14:   return m_snap;
      default: return 32'd0;
    endcase
  endfunction

  task automatic bus_write(input logic [4:0] off, input logic [31:0] d);
    @(negedge clk);
    addr = BASE + {27'd0, off};
    wdata = d;
    we = 1'b1;
    re = 1'b0;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  // One-cycle read; returns DUT data and the model's value at the same moment
  task automatic bus_read(input logic [31:0] a, input logic strobe,
                          output logic [31:0] d, output logic [31:0] e);
    @(negedge clk);
    addr = a;
    re = strobe;
    we = 1'b0;
    #1;
    d = rdata;
    e = m_read(a);
    @(posedge clk);
    #1;
    re = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d, e, exp;
    clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_read(BASE + 32'(i * 4), 1'b0, d, e);
      exp = (i == 2 || i == 3) ? 32'hFFFF_FFFF : 32'd0;
      total++;
      if (d !== exp) begin
        bad++;
        $display("FAIL reset_read off=%0h got=%h want=%h", i * 4, d, exp);
      end
    end
    total++;
    if (timer_irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq got=%b want=0", timer_irq);
    end
  endtask

  task automatic test_basic_irq();
    int k;
    bus_write(5'h08, 32'd10);
    bus_write(5'h0C, 32'd0);
    bus_write(5'h10, 32'd1);
    for (k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (timer_irq) break;
    end
    total++;
    if (k !== 11) begin
      bad++;
      $display("FAIL irq_rise_latency got=%0d want=11", k);
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (timer_irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_level_hold got=%b want=1", timer_irq);
    end
    bus_write(5'h08, 32'd100);
    total++;
    if (timer_irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_after_cmp_write got=%b want=1", timer_irq);
    end
    @(posedge clk);
    #1;
    total++;
    if (timer_irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_drop got=%b want=0", timer_irq);
    end
  endtask

  task automatic test_prescale();
    logic [31:0] d, e, exp_lo, exp_ctrl;
`ifdef MACHINE_TIMER_PRESCALE_EN
    exp_lo = 32'd10;
    exp_ctrl = 32'h0000_0301;
`else
    exp_lo = 32'd40;
    exp_ctrl = 32'h0000_0001;
`endif
    bus_write(5'h10, 32'd0);
    bus_write(5'h00, 32'd0);
    bus_write(5'h04, 32'd0);
    bus_write(5'h10, 32'h0000_0301);
    repeat (40) @(posedge clk);
    bus_read(BASE, 1'b0, d, e);
    total++;
    if (d !== exp_lo) begin
      bad++;
      $display("FAIL prescale_mtime got=%0d want=%0d", d, exp_lo);
    end
    bus_read(BASE + 32'h10, 1'b0, d, e);
    total++;
    if (d !== exp_ctrl) begin
      bad++;
      $display("FAIL prescale_ctrl got=%h want=%h", d, exp_ctrl);
    end
    bus_write(5'h10, 32'd0);
  endtask

  task automatic test_wrap();
    logic [31:0] d, e;
    logic [2:0] irq_seen;
    bus_write(5'h00, 32'hFFFF_FFFE);
    bus_write(5'h04, 32'hFFFF_FFFF);
    bus_write(5'h08, 32'hFFFF_FFFF);
    bus_write(5'h0C, 32'hFFFF_FFFF);
    bus_write(5'h10, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      irq_seen[i] = timer_irq;
    end
    total++;
    if (irq_seen !== 3'b010) begin
      bad++;
      $display("FAIL wrap_irq_seq got=%b want=010", irq_seen);
    end
    bus_write(5'h10, 32'd0);
    bus_read(BASE, 1'b0, d, e);
    total++;
    if (d !== 32'd2) begin
      bad++;
      $display("FAIL wrap_lo got=%h want=2", d);
    end
    bus_read(BASE + 32'h4, 1'b0, d, e);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL wrap_hi got=%h want=0", d);
    end
  endtask

  task automatic test_collision();
    bus_write(5'h10, 32'd1);
    @(negedge clk);
    addr = BASE;
    wdata = 32'd5;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    total++;
    if (rdata !== 32'd5) begin
      bad++;
      $display("FAIL collide_lo got=%0d want=5", rdata);
    end
    @(negedge clk);
    addr = BASE + 32'h4;
    wdata = 32'd7;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    addr = BASE;
    #1;
    total++;
    if (rdata !== 32'd5) begin
      bad++;
      $display("FAIL collide_hi_keeps_lo got=%0d want=5", rdata);
    end
    addr = BASE + 32'h4;
    #1;
    total++;
    if (rdata !== 32'd7) begin
      bad++;
      $display("FAIL collide_hi got=%0d want=7", rdata);
    end
    bus_write(5'h10, 32'd0);
  endtask

  task automatic test_snapshot();
    logic [31:0] d, e;
    bus_write(5'h10, 32'd0);
    bus_write(5'h00, 32'hFFFF_FFFF);
    bus_write(5'h04, 32'd1);
    bus_read(BASE, 1'b1, d, e);
    total++;
    if (d !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL snap_lo got=%h want=ffffffff", d);
    end
    bus_write(5'h10, 32'd1);
    repeat (5) @(posedge clk);
    bus_read(BASE + 32'h14, 1'b0, d, e);
    total++;
    if (d !== 32'd1) begin
      bad++;
      $display("FAIL snap_value got=%h want=1", d);
    end
    bus_read(BASE + 32'h4, 1'b0, d, e);
    total++;
    if (d !== 32'd2) begin
      bad++;
      $display("FAIL snap_live_hi got=%h want=2", d);
    end
    bus_write(5'h10, 32'd0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e;
    bus_write(5'h08, 32'd0);
    bus_write(5'h0C, 32'd0);
    bus_write(5'h10, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (timer_irq !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre_irq got=%b want=1", timer_irq);
    end
    @(negedge clk);
    clr_n = 1'b0;
    we = 1'b1;
    re = 1'b1;
    addr = BASE + 32'h10;
    wdata = 32'd1;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    we = 1'b0;
    re = 1'b0;
    total++;
    if (timer_irq !== 1'b0) begin
      bad++;
      $display("FAIL midreset_irq got=%b want=0", timer_irq);
    end
    bus_read(BASE + 32'h10, 1'b0, d, e);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL midreset_ctrl got=%h want=0", d);
    end
    bus_read(BASE + 32'h8, 1'b0, d, e);
    total++;
    if (d !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL midreset_cmp got=%h want=ffffffff", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, e, w, a;
    bit is_read;
    for (int n = 0; n < 400; n++) begin
      is_read = 1'b0;
      case ($urandom_range(0, 9))
        0: bus_write(5'h00, $urandom_range(0, 200));
        1: bus_write(5'h04, ($urandom_range(0, 7) == 0) ? $urandom : 32'd0);
        2: bus_write(5'h08, $urandom_range(0, 400));
        3: bus_write(5'h0C, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'd0);
        4: begin
          w = $urandom;
          w[15:8] = 8'($urandom_range(0, 3));
          w[0] = ($urandom_range(0, 3) != 0);
          bus_write(5'h10, w);
        end
        5: bus_write(5'(5'h14 + 5'($urandom_range(0, 2) * 4)), $urandom);
        6, 7: begin
          a = BASE + 32'($urandom_range(0, 7) * 4);
          bus_read(a, 1'($urandom_range(0, 1)), d, e);
          is_read = 1'b1;
        end
        8: begin
          a = ($urandom_range(0, 1) == 0) ? BASE - 32'h4 : BASE + 32'($urandom_range(1, 4) * 32);
          bus_read(a, 1'b1, d, e);
          is_read = 1'b1;
        end
        default: begin
          @(posedge clk);
          #1;
        end
      endcase
      if (is_read) begin
        total++;
        if (d !== e) begin
          bad++;
          $display("FAIL rand_read n=%0d addr=%h got=%h want=%h", n, a, d, e);
        end
      end
      total++;
      if (timer_irq !== m_irq) begin
        bad++;
        $display("FAIL rand_irq n=%0d got=%b want=%b", n, timer_irq, m_irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_irq();
    test_prescale();
    test_wrap();
    test_collision();
    test_snapshot();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
